playback_buffer: RTL
====================

# playback_buffer

Waveform playback buffer: the transmit-side counterpart of the capture sample buffer. It accepts a waveform over AXI-Stream from the PS DMA (AXI_MM_WIDTH-bit beats) and packs the beats into a BRAM of PARALLEL_SAMPLES-wide sample words. On a trigger edge it streams the stored words to the DAC datapath. It sits between the DMA MM2S channel and the DAC sample pipeline.

## Interface
- BUFFER_DEPTH, 1024: number of buffer entries; each entry is one parallel sample word. Must be a power of 2.
- PARALLEL_SAMPLES, 16: samples per output word.
- SAMPLE_WIDTH, 16: bits per sample.
- AXI_MM_WIDTH, 128: DMA beat width. PARALLEL_SAMPLES*SAMPLE_WIDTH must equal AXI_MM_WIDTH*RATIO, where RATIO is a power of 2 and RATIO ≥ 1.
- clk  input  1  single clock for the whole block.
- reset  input  1  asynchronous, active-low reset.
- data_in  Axis_If.Slave_Full  AXI_MM_WIDTH  DMA stream (data, valid, ready, last).
- data_out  Axis_If.Master_Full  PARALLEL_SAMPLES*SAMPLE_WIDTH  sample stream to the DAC (data, valid, ready, last).
- trigger  input  1  a rising edge starts playback.
- loaded  output  1  high while a complete waveform is held (state READY).
- busy  output  1  high in LOAD and PLAY.
- overflow  output  1  sticky; set when the DMA sent more than BUFFER_DEPTH entries. Cleared at the start of the next load.

## Operation
- States: IDLE, LOAD, READY, PLAY. Reset enters IDLE.
- IDLE/READY → LOAD: on the first data_in beat accepted (valid && ready). That beat is written at entry 0, subword 0. Any previously stored waveform is discarded.
- LOAD: beats fill an entry LSB-subword first; subword s occupies bits [AXI_MM_WIDTH*s +: AXI_MM_WIDTH]. The entry is written to BRAM when its last subword arrives, or on data_in.last.
- On data_in.last, unfilled subwords of the final entry are zero. length = ceil(beats/RATIO), capped at BUFFER_DEPTH. Next state is READY.
- Beats that would land beyond entry BUFFER_DEPTH-1 are accepted and discarded, and overflow is set. last still ends the load.
- data_in.ready = 1 in IDLE, LOAD, READY; 0 in PLAY.
- READY → PLAY: on trigger rising edge (trigger high while trigger_d low). A trigger edge is ignored in IDLE, LOAD and PLAY.
- PLAY: entries 0..length-1 are output in order. data_out.last is high on entry length-1. After that beat is handshaken, the state returns to READY and the waveform is retained, so it can be replayed.
- loaded = (state == READY); busy = (state == LOAD || state == PLAY).

## Timing
- Reset asserted (at any time, including mid-LOAD or mid-PLAY):
  - State → IDLE; length, addresses and all flags → 0.
  - Outputs: data_out.valid=0, data_out.last=0, data_out.data=0, loaded=0, busy=0, overflow=0.
  - data_in.ready = 1 one cycle after reset deassertion.
  - BRAM contents are not cleared.
- BRAM read latency is 1 cycle and the output is registered.
- First data_out.valid appears 2 cycles after the clk edge that samples the trigger edge.
- AXIS rules on data_out:
  - data and last are stable while valid && !ready.
  - No entry is dropped or duplicated under any ready pattern. The read pipeline stalls, or a 2-entry skid absorbs the in-flight read.
  - With ready held high, one entry is output per cycle with no bubbles.
- data_in.last coinciding with the BUFFER_DEPTH-th entry completing: length=BUFFER_DEPTH and overflow stays 0.
- length==1: the single entry carries last, and playback completes in one handshake.

## Configuration
- PLAYBACK_LOOP_EN defined:
  - Adds input port `stop` (1 bit).
  - PLAY wraps from entry length-1 to entry 0 without a bubble; last is asserted on every pass's final entry.
  - A stop pulse is latched. Playback ends after the final entry of the current pass, and the state goes to READY.
  - A stop pulse outside PLAY is ignored.
- PLAYBACK_LOOP_EN undefined: single-shot playback as described above; no `stop` port.

## Test plan
Bench configuration: BUFFER_DEPTH=8, RATIO=2.
- Load and play: load 6 beats (0x1..0x6, last on beat 6), then trigger. Expect length=3; output entries {2,1},{4,3},{6,5} with last on the third; state returns to READY.
- Odd beat count: load 3 beats. Expect 2 entries, the second = {0,3}; loaded=1 after last.
- Overflow: load 20 beats. Expect overflow=1 and length=8; playback outputs entries from beats 1..16 only. A following 2-beat load clears overflow.
- Backpressure: random data_out.ready at 50% during playback of 8 entries. Expect an in-order sequence with no duplicates, last only on entry 8, and data stable during stalls.
- Mid-play reset and triggers: reset pulled low mid-PLAY gives data_out.valid=0 immediately and IDLE after release. A trigger in IDLE produces no output. A trigger in PLAY does not restart playback.
- With PLAYBACK_LOOP_EN, length=3: 2 passes are output back-to-back (6 beats, last on beats 3 and 6); a stop pulse mid-pass 2 ends playback after beat 6.

Source files
------------

// File: rtl/playback_buffer.sv
// Waveform playback buffer: packs DMA beats into sample-word BRAM and replays them to the DAC on a trigger edge.
// Define PLAYBACK_LOOP_EN for continuous looping playback with a stop input.
module playback_buffer #(
    parameter int BUFFER_DEPTH     = 1024,
    parameter int PARALLEL_SAMPLES = 16,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int AXI_MM_WIDTH     = 128
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [AXI_MM_WIDTH-1:0]                  data_in_data,
    input  logic                                     data_in_valid,
    output logic                                     data_in_ready,
    input  logic                                     data_in_last,
    output logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] data_out_data,
    output logic                                     data_out_valid,
    input  logic                                     data_out_ready,
    output logic                                     data_out_last,
    input  logic                                     trigger,
`ifdef PLAYBACK_LOOP_EN
    input  logic                                     stop,
`endif
    output logic                                     loaded,
    output logic                                     busy,
    output logic                                     overflow
);
    localparam int WORD_W = PARALLEL_SAMPLES * SAMPLE_WIDTH;
    localparam int RATIO  = WORD_W / AXI_MM_WIDTH;
    localparam int SUB_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int AW     = $clog2(BUFFER_DEPTH);
    localparam int LW     = AW + 1;
`ifdef PLAYBACK_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, READY, PLAY} state_t;
    state_t state_reg, state_next;

    logic              ready_reg, loaded_reg, busy_reg, overflow_reg, trigger_d_reg;
    logic [LW-1:0]     wr_cnt_reg, length_reg, rd_addr_reg;
    logic [SUB_W-1:0]  sub_reg;
    logic [WORD_W-1:0] pack_reg, pack_next, mem_q_reg;
    logic              rd_valid_reg, rd_last_reg;
    logic              out_valid_reg, out_last_reg, skid_valid_reg, skid_last_reg;
    logic [WORD_W-1:0] out_data_reg, skid_data_reg;
    logic [WORD_W-1:0] mem [BUFFER_DEPTH];

    logic              accept, first, entry_done, over, wr_en;
    logic              pop, issue, rd_last, trig_edge, stop_hit, play_end;
    logic [LW-1:0]     entry_cur;
    logic [SUB_W-1:0]  sub_cur;
    logic [1:0]        occ;

    // Write side: entry_cur saturates at BUFFER_DEPTH, so its MSB flags a discarded beat.
    assign accept     = data_in_valid && ready_reg;
    assign first      = accept && (state_reg == IDLE || state_reg == READY);
    assign entry_cur  = first ? '0 : wr_cnt_reg;
    assign sub_cur    = first ? '0 : sub_reg;
    assign entry_done = (sub_cur == SUB_W'(RATIO - 1)) || data_in_last;
    assign over       = entry_cur[AW];
    assign wr_en      = accept && entry_done && !over;

    // pack_reg is zero at the start of every entry, so unfilled subwords stay zero on last.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            assign pack_next[gi*AXI_MM_WIDTH +: AXI_MM_WIDTH] =
                (sub_cur == SUB_W'(gi)) ? data_in_data : pack_reg[gi*AXI_MM_WIDTH +: AXI_MM_WIDTH];
        end
    endgenerate

    // Read side: a read is issued only if the out/skid pair can absorb it once it lands.
    assign pop       = out_valid_reg && data_out_ready;
    assign occ       = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg} + {1'b0, rd_valid_reg};
    assign rd_last   = (rd_addr_reg == length_reg - 1'b1);
    assign issue     = (state_reg == PLAY) && (LOOP_EN || rd_addr_reg != length_reg) &&
                       (occ < 2'd2 || (occ == 2'd2 && pop));
    assign trig_edge = trigger && !trigger_d_reg;
    assign play_end  = pop && out_last_reg && stop_hit;

`ifdef PLAYBACK_LOOP_EN
    logic stop_reg;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  stop_reg <= 1'b0;
        else if (state_reg != PLAY)  stop_reg <= 1'b0;
        else if (stop)               stop_reg <= 1'b1;
    end
    assign stop_hit = stop_reg;
`else
    assign stop_hit = 1'b1;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = data_in_last ? READY : LOAD;
            LOAD:    if (accept && data_in_last) state_next = READY;
            READY:   if (accept) state_next = data_in_last ? READY : LOAD;
                     else if (trig_edge) state_next = PLAY;
            PLAY:    if (play_end) state_next = READY;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            ready_reg      <= 1'b0;
            loaded_reg     <= 1'b0;
            busy_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
            trigger_d_reg  <= 1'b0;
            wr_cnt_reg     <= '0;
            length_reg     <= '0;
            rd_addr_reg    <= '0;
            sub_reg        <= '0;
            pack_reg       <= '0;
            rd_valid_reg   <= 1'b0;
            rd_last_reg    <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            out_data_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_last_reg  <= 1'b0;
            skid_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            ready_reg     <= (state_next != PLAY);
            loaded_reg    <= (state_next == READY);
            busy_reg      <= (state_next == LOAD || state_next == PLAY);
            trigger_d_reg <= trigger;

            if (first) overflow_reg <= 1'b0;
            if (accept) begin
                if (over) overflow_reg <= 1'b1;
                if (entry_done) begin
                    wr_cnt_reg <= over ? entry_cur : entry_cur + 1'b1;
                    sub_reg    <= '0;
                    pack_reg   <= '0;
                end else begin
                    wr_cnt_reg <= entry_cur;
                    sub_reg    <= sub_cur + 1'b1;
                    pack_reg   <= pack_next;
                end
                if (data_in_last) length_reg <= over ? LW'(BUFFER_DEPTH) : entry_cur + 1'b1;
            end

            if (state_reg != PLAY && state_next == PLAY) rd_addr_reg <= '0;
            else if (issue) rd_addr_reg <= (LOOP_EN && rd_last) ? '0 : rd_addr_reg + 1'b1;
            rd_last_reg <= rd_last;

            // Leaving PLAY drops any prefetched entries of a pass that will not be sent.
            if (state_next != PLAY) begin
                rd_valid_reg   <= 1'b0;
                out_valid_reg  <= 1'b0;
                out_last_reg   <= 1'b0;
                skid_valid_reg <= 1'b0;
            end else begin
                rd_valid_reg <= issue;
                if (pop) begin
                    out_data_reg   <= skid_valid_reg ? skid_data_reg : mem_q_reg;
                    out_last_reg   <= skid_valid_reg ? skid_last_reg : rd_last_reg;
                    out_valid_reg  <= skid_valid_reg || rd_valid_reg;
                    skid_valid_reg <= skid_valid_reg && rd_valid_reg;
                    if (skid_valid_reg) begin
                        skid_data_reg <= mem_q_reg;
                        skid_last_reg <= rd_last_reg;
                    end
                end else if (rd_valid_reg) begin
                    if (!out_valid_reg) begin
                        out_data_reg  <= mem_q_reg;
                        out_last_reg  <= rd_last_reg;
                        out_valid_reg <= 1'b1;
                    end else begin
                        skid_data_reg  <= mem_q_reg;
                        skid_last_reg  <= rd_last_reg;
                        skid_valid_reg <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[entry_cur[AW-1:0]] <= pack_next;
        if (issue) mem_q_reg <= mem[rd_addr_reg[AW-1:0]];
    end

    assign data_in_ready  = ready_reg;
    assign data_out_data  = out_data_reg;
    assign data_out_valid = out_valid_reg;
    assign data_out_last  = out_last_reg;
    assign loaded         = loaded_reg;
    assign busy           = busy_reg;
    assign overflow       = overflow_reg;
endmodule
